// File: rtl/noc_sched_pkg.sv
// rtl/noc_sched_pkg.sv - shared types for the NoC VC read scheduler
//
// Purpose: FSM state encodings and arbitration class enum shared by the
//          scheduler top and any block that needs to decode its state.
// Contents:
//   sched_state_t  S_IDLE / S_XFER (one-hot 2-bit encoding)
//   sched_cls_t    CLS_HP / CLS_LP (which class won arbitration)
package noc_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b01,
    S_XFER = 2'b10
  } sched_state_t;

  typedef enum logic {
    CLS_HP = 1'b0,
    CLS_LP = 1'b1
  } sched_cls_t;

endpackage

// File: rtl/onehot2bin.sv
// rtl/onehot2bin.sv - one-hot to binary index encoder
//
// Purpose: converts a one-hot (or all-zero) vector into the binary index of
//          its set bit. An all-zero input yields index 0.
// Ports:
//   onehot  in   ONEHOT_W   one-hot vector
//   bin     out  BIN_W      binary index of the set bit
module onehot2bin #(
  parameter int ONEHOT_W = 16,
  parameter int BIN_W    = $clog2(ONEHOT_W)
) (
  input  logic [ONEHOT_W-1:0] onehot,
  output logic [BIN_W-1:0]    bin
);

  // OR of the indices of all set bits; exact when the input is one-hot.
  always_comb begin
    bin = '0;
    for (int i = 0; i < ONEHOT_W; i++) begin
      if (onehot[i]) begin
        bin = bin | BIN_W'(i);
      end
    end
  end

endmodule

// File: rtl/rr_arb_core.sv
// rtl/rr_arb_core.sv - combinational round-robin arbiter core
//
// Purpose: grants the first requester at or after ptr, wrapping N-1 -> 0.
// Ports:
//   req        in   N          request vector
//   ptr        in   clog2(N)   highest-priority index for this decision
//   gnt        out  N          one-hot grant (all zero when req == 0)
//   any_grant  out  1          at least one request present
module rr_arb_core #(
  parameter int N   = 16,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic             any_grant
);

  localparam logic [2*N-1:0] LOW_ONES = {{N{1'b0}}, {N{1'b1}}};
  localparam logic [2*N-1:0] ONE      = {{(2*N-1){1'b0}}, 1'b1};

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] window;
  logic [2*N-1:0] masked;
  logic [2*N-1:0] first;

  // Duplicating the request vector turns the circular search into a linear
  // one: the N-bit window starting at ptr covers ptr..N-1 then 0..ptr-1.
  // The lowest set bit of the masked vector is the winner; folding the two
  // halves back together maps it onto the original index.
  always_comb begin
    req_dbl = {req, req};
    window  = LOW_ONES << ptr;
    masked  = req_dbl & window;
    first   = masked & (~masked + ONE);
    gnt     = first[N-1:0] | first[2*N-1:N];
  end

  assign any_grant = |req;

endmodule

// File: rtl/vc_rd_scheduler.sv
// rtl/vc_rd_scheduler.sv - packet-granular VC receive FIFO read scheduler
//
// Purpose: picks a virtual channel holding a complete packet and drains it
//          flit by flit toward the depacketizer, holding the grant until the
//          tail flit handshakes. High-priority and low-priority classes are
//          each round-robin; an aging counter bounds LP starvation.
// Ports:
//   axi_clk       in   1        clock
//   axi_rst       in   1        synchronous active-high reset
//   sched_en      in   1        allow new grants (in-flight packet completes)
//   empty_vc      in   N        per-VC FIFO empty (FWFT FIFOs)
//   pkt_avail_vc  in   N        per-VC complete packet stored
//   hp_mask_vc    in   N        1 = VC in high-priority class
//   flit_tail     in   1        tail marker of the head flit of VC vc_sel
//   rd_en         out  N        one-hot FIFO pop
//   vc_sel        out  log2(N)  binary index of the granted VC
//   out_valid     out  1        flit valid toward the depacketizer
//   out_last      out  1        current flit is the packet tail
//   out_ready     in   1        depacketizer accepts the flit
//   busy          out  1        a packet is in flight
//   stall_err     out  1        one-cycle pulse on mid-packet empty timeout
module vc_rd_scheduler
  import noc_sched_pkg::*;
#(
  parameter int VIRTUAL_CH_NUM = 16,
  parameter int MAX_LP_WAIT    = 4,
  parameter int STALL_TIMEOUT  = 256
) (
  input  logic                              axi_clk,
  input  logic                              axi_rst,
  input  logic                              sched_en,
  input  logic [VIRTUAL_CH_NUM-1:0]         empty_vc,
  input  logic [VIRTUAL_CH_NUM-1:0]         pkt_avail_vc,
  input  logic [VIRTUAL_CH_NUM-1:0]         hp_mask_vc,
  input  logic                              flit_tail,
  output logic [VIRTUAL_CH_NUM-1:0]         rd_en,
  output logic [$clog2(VIRTUAL_CH_NUM)-1:0] vc_sel,
  output logic                              out_valid,
  output logic                              out_last,
  input  logic                              out_ready,
  output logic                              busy,
  output logic                              stall_err
);

  localparam int N     = VIRTUAL_CH_NUM;
  localparam int VC_W  = $clog2(N);
  localparam int LPW_W = 8;
  localparam int ST_W  = $clog2(STALL_TIMEOUT + 1);

  localparam logic [LPW_W-1:0] LP_WAIT_MAX = LPW_W'(MAX_LP_WAIT);
  localparam logic [ST_W-1:0]  STALL_LAST  = ST_W'(STALL_TIMEOUT - 1);

  sched_state_t     state;
  logic [N-1:0]     grant_oh;
  logic [VC_W-1:0]  hp_ptr;
  logic [VC_W-1:0]  lp_ptr;
  logic [LPW_W-1:0] lp_wait_cnt;
  logic [ST_W-1:0]  stall_cnt;

  logic [N-1:0]     req;
  logic [N-1:0]     hp_req;
  logic [N-1:0]     lp_req;
  logic [N-1:0]     hp_gnt;
  logic [N-1:0]     lp_gnt;
  logic             hp_any;
  logic             lp_any;
  sched_cls_t       win_cls;
  logic [N-1:0]     win_oh;
  logic [VC_W-1:0]  win_idx;
  logic [VC_W-1:0]  next_ptr;
  logic             head_empty;
  logic             pop;

  // A VC is eligible only when a whole packet is stored and the head flit is
  // already visible, so the drain never starts on an empty FIFO.
  always_comb begin
    req    = pkt_avail_vc & ~empty_vc;
    hp_req = req & hp_mask_vc;
    lp_req = req & ~hp_mask_vc;
  end

  rr_arb_core #(.N(N), .PTR_W(VC_W)) u_hp_arb (
    .req       (hp_req),
    .ptr       (hp_ptr),
    .gnt       (hp_gnt),
    .any_grant (hp_any)
  );

  rr_arb_core #(.N(N), .PTR_W(VC_W)) u_lp_arb (
    .req       (lp_req),
    .ptr       (lp_ptr),
    .gnt       (lp_gnt),
    .any_grant (lp_any)
  );

  // LP wins when it has aged out, or when no HP VC is asking.
  always_comb begin
    if ((lp_any && (lp_wait_cnt == LP_WAIT_MAX)) || !hp_any) begin
      win_cls = CLS_LP;
      win_oh  = lp_gnt;
    end else begin
      win_cls = CLS_HP;
      win_oh  = hp_gnt;
    end
  end

  onehot2bin #(.ONEHOT_W(N), .BIN_W(VC_W)) u_win_idx (
    .onehot (win_oh),
    .bin    (win_idx)
  );

  onehot2bin #(.ONEHOT_W(N), .BIN_W(VC_W)) u_sel_idx (
    .onehot (grant_oh),
    .bin    (vc_sel)
  );

  // N is a power of two, so the natural VC_W-bit wrap is the modulo-N step.
  assign next_ptr = win_idx + VC_W'(1);

  // FWFT datapath: the pop happens in the same cycle as the handshake.
  // out_valid is forced low during reset so no pop escapes mid-abandon.
  assign busy       = (state == S_XFER);
  assign head_empty = empty_vc[vc_sel];
  assign out_valid  = busy & ~head_empty & ~axi_rst;
  assign out_last   = flit_tail & out_valid;
  assign pop        = out_valid & out_ready;
  assign rd_en      = pop ? grant_oh : '0;

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      state       <= S_IDLE;
      grant_oh    <= '0;
      hp_ptr      <= '0;
      lp_ptr      <= '0;
      lp_wait_cnt <= '0;
      stall_cnt   <= '0;
      stall_err   <= 1'b0;
    end else begin
      stall_err <= 1'b0;
      case (state)
        S_IDLE: begin
          stall_cnt <= '0;
          if (sched_en && (req != '0)) begin
            state    <= S_XFER;
            grant_oh <= win_oh;
            if (win_cls == CLS_LP) begin
              lp_ptr      <= next_ptr;
              lp_wait_cnt <= '0;
            end else begin
              hp_ptr <= next_ptr;
              if (lp_any && (lp_wait_cnt != LP_WAIT_MAX)) begin
                lp_wait_cnt <= lp_wait_cnt + LPW_W'(1);
              end
            end
          end
        end

        S_XFER: begin
          if (pop && out_last) begin
            state     <= S_IDLE;
            stall_cnt <= '0;
          end else if (head_empty) begin
            // The grant is kept on timeout; the error is only reported.
            if (stall_cnt == STALL_LAST) begin
              stall_err <= 1'b1;
              stall_cnt <= '0;
            end else begin
              stall_cnt <= stall_cnt + ST_W'(1);
            end
          end else begin
            stall_cnt <= '0;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vc_rd_scheduler.sv
// tb/tb_vc_rd_scheduler.sv - directed self-checking bench for vc_rd_scheduler
module tb_vc_rd_scheduler;

  localparam int N = 16;

  logic          axi_clk = 1'b0;
  logic          axi_rst;
  logic          sched_en;
  logic [N-1:0]  empty_vc;
  logic [N-1:0]  pkt_avail_vc;
  logic [N-1:0]  hp_mask_vc;
  logic          flit_tail;
  logic [N-1:0]  rd_en;
  logic [3:0]    vc_sel;
  logic          out_valid;
  logic          out_last;
  logic          out_ready;
  logic          busy;
  logic          stall_err;

  vc_rd_scheduler #(
    .VIRTUAL_CH_NUM (16),
    .MAX_LP_WAIT    (4),
    .STALL_TIMEOUT  (256)
  ) dut (
    .axi_clk      (axi_clk),
    .axi_rst      (axi_rst),
    .sched_en     (sched_en),
    .empty_vc     (empty_vc),
    .pkt_avail_vc (pkt_avail_vc),
    .hp_mask_vc   (hp_mask_vc),
    .flit_tail    (flit_tail),
    .rd_en        (rd_en),
    .vc_sel       (vc_sel),
    .out_valid    (out_valid),
    .out_last     (out_last),
    .out_ready    (out_ready),
    .busy         (busy),
    .stall_err    (stall_err)
  );

  always #5 axi_clk = ~axi_clk;

  // FIFO model: flits stored, packet length, position in packet, endless supply
  int           cnt  [N];
  int           plen [N];
  int           pos  [N];
  int           pops [N];
  bit           inf  [N];
  logic [N-1:0] force_empty;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   grants[$];
  logic prev_busy = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic update_inputs();
    for (int v = 0; v < N; v++) begin
      empty_vc[v]     = (cnt[v] == 0) || force_empty[v];
      pkt_avail_vc[v] = (cnt[v] != 0);
    end
    flit_tail = (pos[vc_sel] == plen[vc_sel] - 1);
    #1;
  endtask

  task automatic step();
    logic [N-1:0] r;
    r = rd_en;
    @(posedge axi_clk);
    @(negedge axi_clk);
    for (int v = 0; v < N; v++) begin
      if (r[v]) begin
        pops[v]++;
        if (!inf[v]) cnt[v]--;
        pos[v] = (pos[v] + 1) % plen[v];
      end
    end
    update_inputs();
    if (busy && !prev_busy) grants.push_back(int'(vc_sel));
    prev_busy = busy;
  endtask

  task automatic clear_all();
    for (int v = 0; v < N; v++) begin
      cnt[v] = 0; plen[v] = 1; pos[v] = 0; pops[v] = 0; inf[v] = 1'b0;
    end
    force_empty = '0;
    update_inputs();
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    sched_en = 1'b0;
    while (busy && k < 50) begin
      step();
      k++;
    end
    check(tag, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int exp2 [6]  = '{2, 5, 9, 2, 5, 9};
  int exp3 [10] = '{4, 4, 4, 4, 7, 4, 4, 4, 4, 7};
  bit rdy5 [5]  = '{1, 0, 0, 1, 1};
  int errs, busy_lo, sel_bad, busy_cyc;

  initial begin
    axi_rst    = 1'b1;
    sched_en   = 1'b0;
    out_ready  = 1'b1;
    hp_mask_vc = '0;
    flit_tail  = 1'b0;
    @(negedge axi_clk);
    clear_all();
    repeat (3) step();
    axi_rst = 1'b0;
    update_inputs();

    // reset state
    check("rst_busy", busy, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_vc_sel", vc_sel, 0);
    check("rst_stall_err", stall_err, 0);

    // 1: 3-flit packet on VC0
    cnt[0] = 3; plen[0] = 3; sched_en = 1'b1;
    update_inputs();
    check("t1_busy_pre", busy, 0);
    step();
    check("t1_busy", busy, 1);
    check("t1_vc_sel", vc_sel, 0);
    check("t1_rd_en_f1", rd_en, 16'h0001);
    check("t1_last_f1", out_last, 0);
    step();
    check("t1_rd_en_f2", rd_en, 16'h0001);
    check("t1_last_f2", out_last, 0);
    step();
    check("t1_rd_en_f3", rd_en, 16'h0001);
    check("t1_last_f3", out_last, 1);
    step();
    check("t1_idle", busy, 0);
    check("t1_rd_en_idle", rd_en, 0);
    check("t1_cnt", cnt[0], 0);

    // 2: LP round-robin among VCs 2, 5, 9 (1-flit packets)
    clear_all();
    sched_en = 1'b1;
    foreach (exp2[i]) begin
      inf[exp2[i]] = 1'b1; cnt[exp2[i]] = 1;
    end
    update_inputs();
    grants.delete();
    busy_cyc = 0;
    repeat (12) begin
      step();
      if (busy) busy_cyc++;
    end
    check("t2_n_grants", grants.size(), 6);
    check("t2_busy_cycles", busy_cyc, 6);
    for (int i = 0; i < 6; i++) check($sformatf("t2_grant%0d", i), grants[i], exp2[i]);
    drain("t2_drain");
    clear_all();

    // 3: HP VC4 vs LP VC7 aging
    hp_mask_vc = 16'h0010;
    inf[4] = 1'b1; cnt[4] = 1;
    inf[7] = 1'b1; cnt[7] = 1;
    sched_en = 1'b1;
    update_inputs();
    grants.delete();
    repeat (20) step();
    check("t3_n_grants", grants.size(), 10);
    for (int i = 0; i < 10; i++) check($sformatf("t3_grant%0d", i), grants[i], exp3[i]);
    drain("t3_drain");
    clear_all();
    hp_mask_vc = '0;

    // 4: mid-packet stall on VC3
    cnt[3] = 3; plen[3] = 3; sched_en = 1'b1;
    update_inputs();
    step();
    check("t4_vc_sel", vc_sel, 3);
    check("t4_rd_en_f1", rd_en, 16'h0008);
    step();
    force_empty[3] = 1'b1;
    update_inputs();
    check("t4_stall_valid", out_valid, 0);
    check("t4_stall_rd_en", rd_en, 0);
    errs = 0; busy_lo = 0; sel_bad = 0;
    repeat (256) begin
      step();
      if (stall_err) errs++;
      if (!busy) busy_lo++;
      if (vc_sel != 4'd3) sel_bad++;
    end
    check("t4_stall_pulses", errs, 1);
    check("t4_busy_low_cycles", busy_lo, 0);
    check("t4_sel_changes", sel_bad, 0);
    force_empty[3] = 1'b0;
    update_inputs();
    check("t4_refill_rd_en", rd_en, 16'h0008);
    check("t4_refill_last_f2", out_last, 0);
    errs = 0;
    step();
    if (stall_err) errs++;
    check("t4_last_f3", out_last, 1);
    check("t4_rd_en_f3", rd_en, 16'h0008);
    step();
    if (stall_err) errs++;
    check("t4_done_busy", busy, 0);
    check("t4_done_cnt", cnt[3], 0);
    check("t4_no_extra_pulse", errs, 0);
    clear_all();

    // 5: backpressure on a 3-flit packet on VC6
    cnt[6] = 3; plen[6] = 3; sched_en = 1'b1; out_ready = 1'b1;
    update_inputs();
    step();
    check("t5_vc_sel", vc_sel, 6);
    for (int i = 0; i < 5; i++) begin
      out_ready = rdy5[i];
      update_inputs();
      check($sformatf("t5_rd_en_c%0d", i), rd_en, rdy5[i] ? 16'h0040 : 16'h0000);
      check($sformatf("t5_valid_c%0d", i), out_valid, 1);
      check($sformatf("t5_last_c%0d", i), out_last, (i == 4) ? 1 : 0);
      step();
    end
    out_ready = 1'b1;
    update_inputs();
    check("t5_done_busy", busy, 0);
    check("t5_pops", pops[6], 3);
    check("t5_cnt", cnt[6], 0);
    clear_all();

    // 6: reset on flit 2 of a 4-flit packet on VC1
    cnt[1] = 4; plen[1] = 4; sched_en = 1'b1;
    update_inputs();
    step();
    check("t6_vc_sel", vc_sel, 1);
    step();
    axi_rst = 1'b1;
    update_inputs();
    check("t6_rst_rd_en_gated", rd_en, 0);
    check("t6_rst_valid_gated", out_valid, 0);
    step();
    check("t6_rst_busy", busy, 0);
    check("t6_rst_rd_en", rd_en, 0);
    check("t6_rst_vc_sel", vc_sel, 0);
    axi_rst = 1'b0;
    cnt[1] = 1; plen[1] = 1; pos[1] = 0;
    cnt[5] = 1; plen[5] = 1;
    update_inputs();
    step();
    check("t6_restart_vc_sel", vc_sel, 1);
    check("t6_restart_rd_en", rd_en, 16'h0002);
    step();
    step();
    check("t6_next_vc_sel", vc_sel, 5);
    drain("t6_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
